// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: mixes COLS_PER_CYCLE columns of the 128-bit state per clock,
// or copies them unchanged when the transaction was flagged as the final (bypass) round.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gIllegalCols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Busy = 2'd1,
    Done = 2'd2
  } stateT;

  // Column counter wraps to 0 after the last chunk, so a step of 4 encodes as 0.
  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE % 4);

  stateT          state_q;
  logic [1:0]     col_cnt_q;
  logic [127:0]   work_q;
  logic [127:0]   result_q;
  logic [127:0]   result_d;
  logic           bypass_q;
  logic           lastChunk;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixColumn(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [31:0] getColumn(input logic [127:0] s, input int c);
    return {s[127-8*c -: 8], s[95-8*c -: 8], s[63-8*c -: 8], s[31-8*c -: 8]};
  endfunction

  // A column belongs to the current chunk when its distance above col_cnt is below the chunk size.
  always_comb begin
    logic [1:0]  colOff;
    logic [31:0] colVal;
    result_d = result_q;
    colOff   = 2'd0;
    colVal   = 32'h0;
    for (int c = 0; c < 4; c++) begin
      colOff = 2'(c) - col_cnt_q;
      if (int'(colOff) < COLS_PER_CYCLE) begin
        colVal = bypass_q ? getColumn(work_q, c) : mixColumn(getColumn(work_q, c));
        for (int r = 0; r < 4; r++) begin
          result_d[127-32*r-8*c -: 8] = colVal[31-8*r -: 8];
        end
      end
    end
  end

  assign lastChunk = ({1'b0, col_cnt_q} + 3'(COLS_PER_CYCLE)) >= 3'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= Idle;
      col_cnt_q <= 2'd0;
      work_q    <= 128'h0;
      result_q  <= 128'h0;
      bypass_q  <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (in_valid) begin
            work_q    <= state_in;
            bypass_q  <= bypass_in;
            col_cnt_q <= 2'd0;
            state_q   <= Busy;
          end
        end
        Busy: begin
          result_q  <= result_d;
          col_cnt_q <= col_cnt_q + ColStep;
          if (lastChunk) begin
            state_q <= Done;
          end
        end
        Done: begin
          if (out_ready) begin
            state_q <= Idle;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign in_ready  = (state_q == Idle);
  assign out_valid = (state_q == Done);
  assign state_out = result_q;

endmodule
